// File: rtl/rand_dispatch.sv
// Shared LCG random-number server: one value per grant, round-robin across
// requesters, with optional warm-up discard after every reset or reseed.
module rand_dispatch #(
    parameter int          NREQ   = 4,
    parameter int          N      = 32,
    parameter int unsigned A      = 1103515245,
    parameter int unsigned C      = 12345,
    parameter int unsigned SEED   = 1,
    parameter int unsigned WARMUP = 0
) (
    input  logic            clk50M,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            seed_we,
    input  logic [N-1:0]    seed_in,
    output logic [NREQ-1:0] gnt,
    output logic [N-1:0]    rand_out,
    output logic            busy
);

    localparam int           PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [N-1:0] A_N      = N'(A);
    localparam logic [N-1:0] C_N      = N'(C);
    localparam logic [N-1:0] SEED_N   = N'(SEED);
    localparam logic [7:0]   WARM_CNT = 8'(WARMUP);
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NREQ - 1);

    typedef enum logic {
        RUN  = 1'b0,
        WARM = 1'b1
    } fsm_t;

    fsm_t             fsm, fsm_d;
    logic [7:0]       cnt, cnt_d;
    logic [N-1:0]     state, state_d;
    logic [N-1:0]     rand_d;
    logic [NREQ-1:0]  gnt_d;
    logic [NREQ-1:0]  last_gnt, last_d;
    logic [PTR_W-1:0] rr_ptr, rr_d;

    logic [N-1:0]     lcg_next;
    logic [NREQ-1:0]  eligible;
    logic [PTR_W-1:0] winner;
    logic             found;

    // Product is truncated to N bits, which is exactly the mod 2^N step.
    assign lcg_next = state * A_N + C_N;

    // A requester just granted is masked for one edge so its stale req is not
    // served twice from one request.
    assign eligible = req & ~last_gnt;
    assign busy     = (fsm == WARM);

    // Round-robin search starts one past the last winner and wraps.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = rr_ptr;
        idx    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!found && eligible[PTR_W'(idx)]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        fsm_d   = fsm;
        cnt_d   = cnt;
        state_d = state;
        rand_d  = rand_out;
        rr_d    = rr_ptr;
        last_d  = last_gnt;
        gnt_d   = '0;

        if (seed_we) begin
            state_d = seed_in;
            last_d  = '0;
            cnt_d   = WARM_CNT;
            if (WARMUP > 0) fsm_d = WARM;
            else            fsm_d = RUN;
        end else begin
            case (fsm)
                WARM: begin
                    state_d = lcg_next;
                    cnt_d   = cnt - 8'd1;
                    if (cnt == 8'd1) fsm_d = RUN;
                end
                default: begin
                    if (found) begin
                        gnt_d   = NREQ'(1) << winner;
                        last_d  = NREQ'(1) << winner;
                        rand_d  = lcg_next;
                        state_d = lcg_next;
                        rr_d    = winner;
                    end else begin
                        last_d  = '0;
                    end
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            state    <= SEED_N;
            gnt      <= '0;
            rand_out <= '0;
            rr_ptr   <= PTR_INIT;
            last_gnt <= '0;
            cnt      <= WARM_CNT;
            if (WARMUP > 0) fsm <= WARM;
            else            fsm <= RUN;
        end else begin
            state    <= state_d;
            gnt      <= gnt_d;
            rand_out <= rand_d;
            rr_ptr   <= rr_d;
            last_gnt <= last_d;
            cnt      <= cnt_d;
            fsm      <= fsm_d;
        end
    end

endmodule

// File: tb/tb_rand_dispatch.sv
// Bench for rand_dispatch: three instances (WARMUP 0, 3, 5) on shared inputs,
// directed scenarios plus randomized traffic against a cycle-level model.
module tb_rand_dispatch;

    logic        clk50M = 1'b0;
    logic        rst = 1'b1;
    logic        seed_we = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] seed_in = '0;

    logic [3:0]  gnt_w0, gnt_w3, gnt_w5;
    logic [31:0] rout_w0, rout_w3, rout_w5;
    logic        busy_w0, busy_w3, busy_w5;

    int checks   = 0;
    int failures = 0;

    always #10 clk50M = ~clk50M;

    rand_dispatch #(.WARMUP(0)) u_w0 (
        .clk50M(clk50M), .rst(rst), .req(req), .seed_we(seed_we), .seed_in(seed_in),
        .gnt(gnt_w0), .rand_out(rout_w0), .busy(busy_w0)
    );
    rand_dispatch #(.WARMUP(3)) u_w3 (
        .clk50M(clk50M), .rst(rst), .req(req), .seed_we(seed_we), .seed_in(seed_in),
        .gnt(gnt_w3), .rand_out(rout_w3), .busy(busy_w3)
    );
    rand_dispatch #(.WARMUP(5)) u_w5 (
        .clk50M(clk50M), .rst(rst), .req(req), .seed_we(seed_we), .seed_in(seed_in),
        .gnt(gnt_w5), .rand_out(rout_w5), .busy(busy_w5)
    );

    // Reference: LCG evaluated with 64-bit arithmetic and reduced mod 2^32.
    function automatic logic [31:0] lcg(input logic [31:0] x);
        longint unsigned p;
        p = {32'b0, x} * 64'd1103515245 + 64'd12345;
        return p[31:0];
    endfunction

    function automatic logic [31:0] lcg_n(input logic [31:0] x, input int n);
        logic [31:0] v;
        v = x;
        for (int i = 0; i < n; i++) v = lcg(v);
        return v;
    endfunction

    typedef struct {
        logic [31:0] st;
        logic [31:0] rout;
        logic [3:0]  gnt;
        logic [3:0]  last;
        int          ptr;
        int          remaining;
    } model_t;

    model_t m0, m3, m5;

    function automatic model_t model_step(input model_t m, input logic r, input logic [3:0] rq,
                                          input logic sw, input logic [31:0] si, input int warmup);
        model_t     n;
        logic [3:0] elig;
        n     = m;
        n.gnt = '0;
        if (r) begin
            n.st = 32'd1; n.rout = '0; n.ptr = 3; n.last = '0; n.remaining = warmup;
        end else if (sw) begin
            n.st = si; n.last = '0; n.remaining = warmup;
        end else if (m.remaining > 0) begin
            n.st = lcg(m.st);
            n.remaining = m.remaining - 1;
        end else begin
            elig   = rq & ~m.last;
            n.last = '0;
            for (int i = 1; i <= 4; i++) begin
                int w;
                w = (m.ptr + i) % 4;
                if (n.gnt == 4'b0 && ((elig >> w) & 4'd1) != 4'd0) begin
                    n.gnt  = 4'd1 << w;
                    n.last = 4'd1 << w;
                    n.ptr  = w;
                    n.st   = lcg(m.st);
                    n.rout = n.st;
                end
            end
        end
        return n;
    endfunction

    // Drive inputs on the falling edge, advance the models on the rising
    // edge, and return 1 ns later so outputs are settled for sampling.
    task automatic tick(input logic r, input logic [3:0] rq, input logic sw, input logic [31:0] si);
        @(negedge clk50M);
        rst = r; req = rq; seed_we = sw; seed_in = si;
        @(posedge clk50M);
        m0 = model_step(m0, r, rq, sw, si, 0);
        m3 = model_step(m3, r, rq, sw, si, 3);
        m5 = model_step(m5, r, rq, sw, si, 5);
        #1;
    endtask

    task automatic test_reset;
        tick(1'b1, 4'b0000, 1'b0, '0);
        tick(1'b1, 4'b1111, 1'b1, 32'h1234_5678);
        checks++; if (gnt_w0 !== 4'b0) begin failures++; $display("FAIL reset_gnt: got %b expected 0000", gnt_w0); end
        checks++; if (rout_w0 !== 32'h0) begin failures++; $display("FAIL reset_rand_out: got %h expected 00000000", rout_w0); end
        checks++; if (busy_w0 !== 1'b0) begin failures++; $display("FAIL reset_busy_w0: got %b expected 0", busy_w0); end
        checks++; if (busy_w3 !== 1'b1) begin failures++; $display("FAIL reset_busy_w3: got %b expected 1", busy_w3); end
        checks++; if (busy_w5 !== 1'b1) begin failures++; $display("FAIL reset_busy_w5: got %b expected 1", busy_w5); end
    endtask

    task automatic test_single;
        tick(1'b1, 4'b0000, 1'b0, '0);
        tick(1'b0, 4'b0001, 1'b0, '0);
        checks++; if (gnt_w0 !== 4'b0001) begin failures++; $display("FAIL single_first_gnt: got %b expected 0001", gnt_w0); end
        checks++; if (rout_w0 !== 32'h41C6_7EA6) begin failures++; $display("FAIL single_first_value: got %h expected 41c67ea6", rout_w0); end
        tick(1'b0, 4'b0001, 1'b0, '0);
        checks++; if (gnt_w0 !== 4'b0000) begin failures++; $display("FAIL single_masked: got %b expected 0000", gnt_w0); end
        checks++; if (rout_w0 !== 32'h41C6_7EA6) begin failures++; $display("FAIL single_hold: got %h expected 41c67ea6", rout_w0); end
        tick(1'b0, 4'b0001, 1'b0, '0);
        checks++; if (gnt_w0 !== 4'b0001) begin failures++; $display("FAIL single_second_gnt: got %b expected 0001", gnt_w0); end
        checks++; if (rout_w0 !== lcg(32'h41C6_7EA6)) begin failures++; $display("FAIL single_second_value: got %h expected %h", rout_w0, lcg(32'h41C6_7EA6)); end
    endtask

    task automatic test_round_robin;
        tick(1'b1, 4'b0000, 1'b0, '0);
        for (int k = 1; k <= 9; k++) begin
            tick(1'b0, 4'b1111, 1'b0, '0);
            checks++;
            if (gnt_w0 !== (4'd1 << ((k - 1) % 4))) begin
                failures++; $display("FAIL rr_order k=%0d: got %b expected %b", k, gnt_w0, 4'd1 << ((k - 1) % 4));
            end
            checks++;
            if (rout_w0 !== lcg_n(32'd1, k)) begin
                failures++; $display("FAIL rr_value k=%0d: got %h expected %h", k, rout_w0, lcg_n(32'd1, k));
            end
        end
    endtask

    task automatic test_reseed;
        tick(1'b1, 4'b0000, 1'b0, '0);
        tick(1'b0, 4'b0100, 1'b1, 32'h0);
        checks++; if (gnt_w0 !== 4'b0) begin failures++; $display("FAIL reseed_edge_gnt: got %b expected 0000", gnt_w0); end
        checks++; if (rout_w0 !== 32'h0) begin failures++; $display("FAIL reseed_edge_hold: got %h expected 00000000", rout_w0); end
        checks++; if (busy_w0 !== 1'b0) begin failures++; $display("FAIL reseed_busy: got %b expected 0", busy_w0); end
        tick(1'b0, 4'b0100, 1'b0, '0);
        checks++; if (gnt_w0 !== 4'b0100) begin failures++; $display("FAIL reseed_gnt: got %b expected 0100", gnt_w0); end
        checks++; if (rout_w0 !== 32'h0000_3039) begin failures++; $display("FAIL reseed_value: got %h expected 00003039", rout_w0); end
    endtask

    task automatic test_warmup;
        tick(1'b1, 4'b0000, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy_w3 !== 1'b1 || gnt_w3 !== 4'b0) begin
                failures++; $display("FAIL warm3_busy k=%0d: got busy=%b gnt=%b expected busy=1 gnt=0000", k, busy_w3, gnt_w3);
            end
            tick(1'b0, 4'b0010, 1'b0, '0);
        end
        checks++;
        if (busy_w3 !== 1'b0 || gnt_w3 !== 4'b0) begin
            failures++; $display("FAIL warm3_done: got busy=%b gnt=%b expected busy=0 gnt=0000", busy_w3, gnt_w3);
        end
        tick(1'b0, 4'b0010, 1'b0, '0);
        checks++; if (gnt_w3 !== 4'b0010) begin failures++; $display("FAIL warm3_first_gnt: got %b expected 0010", gnt_w3); end
        checks++; if (rout_w3 !== lcg_n(32'd1, 4)) begin failures++; $display("FAIL warm3_first_value: got %h expected %h", rout_w3, lcg_n(32'd1, 4)); end
    endtask

    task automatic test_reseed_warm;
        tick(1'b1, 4'b0000, 1'b0, '0);
        tick(1'b0, 4'b0001, 1'b0, '0);
        tick(1'b0, 4'b0001, 1'b0, '0);
        tick(1'b0, 4'b0001, 1'b1, 32'hDEAD_BEEF);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (busy_w5 !== 1'b1 || gnt_w5 !== 4'b0) begin
                failures++; $display("FAIL warm5_restart k=%0d: got busy=%b gnt=%b expected busy=1 gnt=0000", k, busy_w5, gnt_w5);
            end
            tick(1'b0, 4'b0001, 1'b0, '0);
        end
        checks++;
        if (busy_w5 !== 1'b0 || gnt_w5 !== 4'b0) begin
            failures++; $display("FAIL warm5_done: got busy=%b gnt=%b expected busy=0 gnt=0000", busy_w5, gnt_w5);
        end
        tick(1'b0, 4'b0001, 1'b0, '0);
        checks++; if (gnt_w5 !== 4'b0001) begin failures++; $display("FAIL warm5_first_gnt: got %b expected 0001", gnt_w5); end
        checks++;
        if (rout_w5 !== lcg_n(32'hDEAD_BEEF, 6)) begin
            failures++; $display("FAIL warm5_first_value: got %h expected %h", rout_w5, lcg_n(32'hDEAD_BEEF, 6));
        end
    endtask

    task automatic test_reset_midstream;
        tick(1'b1, 4'b0000, 1'b0, '0);
        for (int k = 0; k < 3; k++) tick(1'b0, 4'b0110, 1'b0, '0);
        tick(1'b1, 4'b0110, 1'b0, '0);
        checks++; if (gnt_w0 !== 4'b0) begin failures++; $display("FAIL midreset_gnt: got %b expected 0000", gnt_w0); end
        checks++; if (rout_w0 !== 32'h0) begin failures++; $display("FAIL midreset_rand_out: got %h expected 00000000", rout_w0); end
        tick(1'b0, 4'b0110, 1'b0, '0);
        checks++; if (gnt_w0 !== 4'b0010) begin failures++; $display("FAIL midreset_first_gnt: got %b expected 0010", gnt_w0); end
        checks++; if (rout_w0 !== 32'h41C6_7EA6) begin failures++; $display("FAIL midreset_first_value: got %h expected 41c67ea6", rout_w0); end
    endtask

    task automatic test_random;
        logic [3:0]  rq;
        logic        sw;
        logic        r;
        logic [31:0] si;
        tick(1'b1, 4'b0000, 1'b0, '0);
        for (int k = 0; k < 600; k++) begin
            rq = 4'($urandom);
            sw = ($urandom_range(0, 31) == 0);
            r  = ($urandom_range(0, 79) == 0);
            si = $urandom;
            tick(r, rq, sw, si);
            checks++;
            if (gnt_w0 !== m0.gnt || rout_w0 !== m0.rout || busy_w0 !== (m0.remaining > 0)) begin
                failures++; $display("FAIL rand_w0 cyc=%0d: got gnt=%b val=%h busy=%b expected gnt=%b val=%h busy=%b",
                                     k, gnt_w0, rout_w0, busy_w0, m0.gnt, m0.rout, m0.remaining > 0);
            end
            checks++;
            if (gnt_w3 !== m3.gnt || rout_w3 !== m3.rout || busy_w3 !== (m3.remaining > 0)) begin
                failures++; $display("FAIL rand_w3 cyc=%0d: got gnt=%b val=%h busy=%b expected gnt=%b val=%h busy=%b",
                                     k, gnt_w3, rout_w3, busy_w3, m3.gnt, m3.rout, m3.remaining > 0);
            end
            checks++;
            if (gnt_w5 !== m5.gnt || rout_w5 !== m5.rout || busy_w5 !== (m5.remaining > 0)) begin
                failures++; $display("FAIL rand_w5 cyc=%0d: got gnt=%b val=%h busy=%b expected gnt=%b val=%h busy=%b",
                                     k, gnt_w5, rout_w5, busy_w5, m5.gnt, m5.rout, m5.remaining > 0);
            end
            checks++;
            if (!$onehot0(gnt_w0) || !$onehot0(gnt_w3) || !$onehot0(gnt_w5)) begin
                failures++; $display("FAIL rand_onehot cyc=%0d: got %b %b %b expected zero or one-hot", k, gnt_w0, gnt_w3, gnt_w5);
            end
        end
    endtask

    initial begin
        m0 = '{st: 32'd1, rout: '0, gnt: '0, last: '0, ptr: 3, remaining: 0};
        m3 = '{st: 32'd1, rout: '0, gnt: '0, last: '0, ptr: 3, remaining: 3};
        m5 = '{st: 32'd1, rout: '0, gnt: '0, last: '0, ptr: 3, remaining: 5};
        test_reset;
        test_single;
        test_round_robin;
        test_reseed;
        test_warmup;
        test_reseed_warm;
        test_reset_midstream;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
